// File: rtl/wakeup_status_array_pkg.sv
// Shared types and helpers for the wakeup status array.
// Contents: array sizing constants, source-type encodings, the robIdx struct,
// the robIdx age compare (is_after) and the lowest-set-bit picker.
package wakeup_status_array_pkg;

  localparam int unsigned ENTRIES = 8;
  localparam int unsigned NUM_WK  = 2;
  localparam int unsigned PREG_W  = 6;
  localparam int unsigned ROB_W   = 5;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_INT  = 2'd1,
    SRC_FP   = 2'd2,
    SRC_RSVD = 2'd3
  } src_type_e;

  typedef struct packed {
    logic             flag;
    logic [ROB_W-1:0] value;
  } rob_idx_t;

  // True when a is younger than r; the flag flips each time the ROB wraps.
  function automatic logic is_after(input rob_idx_t a, input rob_idx_t r);
    return (a.flag != r.flag) ^ (a.value > r.value);
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [IDX_W-1:0] pick_lowest(input logic [ENTRIES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wakeup_status_array_if.sv
// Bus bundle for the wakeup status array: enqueue, wakeup ports, issue
// (deq) handshake and redirect. master = producer/consumer side, slave = array.
interface wakeup_status_array_if;
  import wakeup_status_array_pkg::*;

  logic                     enq_valid;
  logic                     enq_ready;
  logic [2*PREG_W-1:0]      enq_psrc;
  logic [3:0]               enq_srcType;
  logic [1:0]               enq_srcReady;
  logic                     enq_robFlag;
  logic [ROB_W-1:0]         enq_robValue;

  logic [NUM_WK-1:0]        wk_valid;
  logic [NUM_WK-1:0]        wk_rfWen;
  logic [NUM_WK-1:0]        wk_fpWen;
  logic [NUM_WK*PREG_W-1:0] wk_pdest;

  logic                     deq_valid;
  logic                     deq_ready;
  logic [IDX_W-1:0]         deq_idx;
  logic                     deq_robFlag;
  logic [ROB_W-1:0]         deq_robValue;

  logic                     redirect_valid;
  logic                     redirect_level;
  logic                     redirect_robFlag;
  logic [ROB_W-1:0]         redirect_robValue;

  modport master (
    output enq_valid, enq_psrc, enq_srcType, enq_srcReady, enq_robFlag, enq_robValue,
    output wk_valid, wk_rfWen, wk_fpWen, wk_pdest,
    output deq_ready,
    output redirect_valid, redirect_level, redirect_robFlag, redirect_robValue,
    input  enq_ready, deq_valid, deq_idx, deq_robFlag, deq_robValue
  );

  modport slave (
    input  enq_valid, enq_psrc, enq_srcType, enq_srcReady, enq_robFlag, enq_robValue,
    input  wk_valid, wk_rfWen, wk_fpWen, wk_pdest,
    input  deq_ready,
    input  redirect_valid, redirect_level, redirect_robFlag, redirect_robValue,
    output enq_ready, deq_valid, deq_idx, deq_robFlag, deq_robValue
  );

endinterface

// File: rtl/wakeup_status_array_src_match.sv
// Combinational wakeup hit for one source tag against all wakeup ports.
// Ports: i_tag/i_type = source tag and type; i_wk_* = wakeup port bundle;
//        o_hit_c = some port wakes this source.
module wakeup_src_match
  import wakeup_status_array_pkg::*;
(
  input  logic [PREG_W-1:0]        i_tag,
  input  logic [1:0]               i_type,
  input  logic [NUM_WK-1:0]        i_wk_valid,
  input  logic [NUM_WK-1:0]        i_wk_rfWen,
  input  logic [NUM_WK-1:0]        i_wk_fpWen,
  input  logic [NUM_WK*PREG_W-1:0] i_wk_pdest,
  output logic                     o_hit_c
);

  // A port hits only when its write target register file matches the source type.
  always_comb begin
    o_hit_c = 1'b0;
    for (int i = 0; i < int'(NUM_WK); i++) begin
      if (i_wk_valid[i] && (i_wk_pdest[i*PREG_W +: PREG_W] == i_tag) &&
          (((i_type == SRC_INT) && i_wk_rfWen[i]) ||
           ((i_type == SRC_FP)  && i_wk_fpWen[i]))) begin
        o_hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wakeup_status_array.sv
// Status array of waiting micro-ops: tracks two source-ready bits per entry,
// wakes sources from the wakeup ports, picks the lowest fully-ready entry for
// issue and squashes entries younger than a redirect.
// Ports: clock, reset (async active-low), bus (slave side of the array bundle).
module wakeup_status_array
  import wakeup_status_array_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  wakeup_status_array_if.slave bus
);

  logic [ENTRIES-1:0] r_valid;
  logic [PREG_W-1:0]  r_psrc [ENTRIES][2];
  logic [1:0]         r_type [ENTRIES][2];
  logic               r_rdy  [ENTRIES][2];
  rob_idx_t           r_rob  [ENTRIES];

  logic               w_hit [ENTRIES][2];
  logic [PREG_W-1:0]  w_enq_tag  [2];
  logic [1:0]         w_enq_type [2];
  logic               w_enq_hit  [2];
  logic               w_enq_rdy  [2];

  logic [ENTRIES-1:0] w_free;
  logic [ENTRIES-1:0] w_cand;
  logic [ENTRIES-1:0] w_flush;
  logic [IDX_W-1:0]   w_alloc_idx;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_enq_ready;
  logic               w_deq_valid;
  logic               w_enq_fire;
  logic               w_deq_fire;
  rob_idx_t           w_redir;

  // Wakeup matchers: two per stored entry plus two for the incoming micro-op.
  for (genvar e = 0; e < int'(ENTRIES); e++) begin : g_ent
    for (genvar s = 0; s < 2; s++) begin : g_src
      wakeup_src_match u_match (
        .i_tag      (r_psrc[e][s]),
        .i_type     (r_type[e][s]),
        .i_wk_valid (bus.wk_valid),
        .i_wk_rfWen (bus.wk_rfWen),
        .i_wk_fpWen (bus.wk_fpWen),
        .i_wk_pdest (bus.wk_pdest),
        .o_hit_c    (w_hit[e][s])
      );
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_enq
    assign w_enq_tag[s]  = bus.enq_psrc[s*PREG_W +: PREG_W];
    assign w_enq_type[s] = bus.enq_srcType[2*s +: 2];

    wakeup_src_match u_match (
      .i_tag      (w_enq_tag[s]),
      .i_type     (w_enq_type[s]),
      .i_wk_valid (bus.wk_valid),
      .i_wk_rfWen (bus.wk_rfWen),
      .i_wk_fpWen (bus.wk_fpWen),
      .i_wk_pdest (bus.wk_pdest),
      .o_hit_c    (w_enq_hit[s])
    );

    // None/reserved sources have nothing to wait for.
    assign w_enq_rdy[s] = bus.enq_srcReady[s] | w_enq_hit[s] |
                          ~((w_enq_type[s] == SRC_INT) | (w_enq_type[s] == SRC_FP));
  end

  // Allocation, selection and flush decode from registered state only.
  always_comb begin
    w_free        = ~r_valid;
    w_alloc_idx   = pick_lowest(w_free);
    w_redir.flag  = bus.redirect_robFlag;
    w_redir.value = bus.redirect_robValue;
    for (int e = 0; e < int'(ENTRIES); e++) begin
      w_cand[e]  = r_valid[e] & r_rdy[e][0] & r_rdy[e][1];
      w_flush[e] = bus.redirect_valid & r_valid[e] &
                   (is_after(r_rob[e], w_redir) |
                    (bus.redirect_level & (r_rob[e] == w_redir)));
    end
    w_sel_idx = pick_lowest(w_cand);
  end

  assign w_enq_ready = (|w_free) & ~bus.redirect_valid;
  assign w_deq_valid = (|w_cand) & ~bus.redirect_valid;
  assign w_enq_fire  = bus.enq_valid & w_enq_ready;
  assign w_deq_fire  = w_deq_valid & bus.deq_ready;

  assign bus.enq_ready    = w_enq_ready;
  assign bus.deq_valid    = w_deq_valid;
  assign bus.deq_idx      = w_deq_valid ? w_sel_idx : '0;
  assign bus.deq_robFlag  = w_deq_valid & r_rob[w_sel_idx].flag;
  assign bus.deq_robValue = w_deq_valid ? r_rob[w_sel_idx].value : '0;

  // Per-entry state; flush and issue free a slot, enq writes the chosen free slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int e = 0; e < int'(ENTRIES); e++) begin
        r_rob[e] <= '0;
        for (int s = 0; s < 2; s++) begin
          r_psrc[e][s] <= '0;
          r_type[e][s] <= SRC_NONE;
          r_rdy[e][s]  <= 1'b0;
        end
      end
    end else begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        if (w_flush[e] || (w_deq_fire && (w_sel_idx == IDX_W'(e)))) begin
          r_valid[e] <= 1'b0;
        end else if (w_enq_fire && (w_alloc_idx == IDX_W'(e))) begin
          r_valid[e]     <= 1'b1;
          r_rob[e].flag  <= bus.enq_robFlag;
          r_rob[e].value <= bus.enq_robValue;
          for (int s = 0; s < 2; s++) begin
            r_psrc[e][s] <= w_enq_tag[s];
            r_type[e][s] <= w_enq_type[s];
            r_rdy[e][s]  <= w_enq_rdy[s];
          end
        end else if (r_valid[e]) begin
          for (int s = 0; s < 2; s++) begin
            r_rdy[e][s] <= r_rdy[e][s] | w_hit[e][s];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wakeup_status_array.sv
// Self-checking bench for wakeup_status_array: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the slot array.
module tb_wakeup_status_array;
  import wakeup_status_array_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  wakeup_status_array_if bus ();

  wakeup_status_array dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model state
  bit m_valid [ENTRIES];
  int m_psrc  [ENTRIES][2];
  int m_type  [ENTRIES][2];
  bit m_rdy   [ENTRIES][2];
  int m_flag  [ENTRIES];
  int m_val   [ENTRIES];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Age compare via circular distance over a ring of 2^(ROB_W+1) positions.
  function automatic bit m_after(input int af, input int av, input int rf, input int rv);
    int span;
    int d;
    span = 1 << (ROB_W + 1);
    d = ((af * (1 << ROB_W) + av) - (rf * (1 << ROB_W) + rv) + span) % span;
    return (d >= 1) && (d <= (span / 2));
  endfunction

  function automatic bit m_wake(input int tag, input int typ);
    for (int i = 0; i < int'(NUM_WK); i++) begin
      if (bus.wk_valid[i] && (int'(bus.wk_pdest[i*PREG_W +: PREG_W]) == tag) &&
          ((typ == 1 && bus.wk_rfWen[i]) || (typ == 2 && bus.wk_fpWen[i])))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idle();
    bus.enq_valid = 0; bus.enq_psrc = '0; bus.enq_srcType = '0; bus.enq_srcReady = '0;
    bus.enq_robFlag = 0; bus.enq_robValue = '0;
    bus.wk_valid = '0; bus.wk_rfWen = '0; bus.wk_fpWen = '0; bus.wk_pdest = '0;
    bus.deq_ready = 0;
    bus.redirect_valid = 0; bus.redirect_level = 0; bus.redirect_robFlag = 0; bus.redirect_robValue = '0;
  endtask

  task automatic set_enq(input int p0, input int p1, input logic [3:0] typ, input logic [1:0] rdy,
                         input int flag, input int val);
    bus.enq_valid    = 1;
    bus.enq_psrc     = {PREG_W'(p1), PREG_W'(p0)};
    bus.enq_srcType  = typ;
    bus.enq_srcReady = rdy;
    bus.enq_robFlag  = 1'(flag);
    bus.enq_robValue = ROB_W'(val);
  endtask

  task automatic set_wk(input int port, input int pdest, input bit rf, input bit fp);
    bus.wk_valid[port] = 1'b1;
    bus.wk_rfWen[port] = rf;
    bus.wk_fpWen[port] = fp;
    bus.wk_pdest[port*PREG_W +: PREG_W] = PREG_W'(pdest);
  endtask

  task automatic set_redirect(input int level, input int flag, input int val);
    bus.redirect_valid    = 1;
    bus.redirect_level    = 1'(level);
    bus.redirect_robFlag  = 1'(flag);
    bus.redirect_robValue = ROB_W'(val);
  endtask

  // One cycle: compare outputs against the model, advance the model, wait for next negedge.
  task automatic step();
    int ff;
    int sel;
    bit e_er;
    bit e_dv;
    bit wk [ENTRIES][2];
    int typ;
    #1;
    ff = -1;
    sel = -1;
    for (int e = 0; e < int'(ENTRIES); e++) begin
      if (!m_valid[e] && ff < 0) ff = e;
      if (m_valid[e] && m_rdy[e][0] && m_rdy[e][1] && sel < 0) sel = e;
    end
    e_er = (ff >= 0) && !bus.redirect_valid;
    e_dv = (sel >= 0) && !bus.redirect_valid;
    check("enq_ready", 32'(bus.enq_ready), 32'(e_er));
    check("deq_valid", 32'(bus.deq_valid), 32'(e_dv));
    if (e_dv) begin
      check("deq_idx", 32'(bus.deq_idx), 32'(sel));
      check("deq_robFlag", 32'(bus.deq_robFlag), 32'(m_flag[sel]));
      check("deq_robValue", 32'(bus.deq_robValue), 32'(m_val[sel]));
    end else begin
      check("deq_idx_idle", 32'(bus.deq_idx), 32'd0);
      check("deq_robFlag_idle", 32'(bus.deq_robFlag), 32'd0);
      check("deq_robValue_idle", 32'(bus.deq_robValue), 32'd0);
    end

    for (int e = 0; e < int'(ENTRIES); e++)
      for (int s = 0; s < 2; s++)
        wk[e][s] = m_wake(m_psrc[e][s], m_type[e][s]);
    for (int e = 0; e < int'(ENTRIES); e++)
      for (int s = 0; s < 2; s++)
        if (m_valid[e] && wk[e][s]) m_rdy[e][s] = 1'b1;

    if (bus.redirect_valid) begin
      for (int e = 0; e < int'(ENTRIES); e++) begin
        if (m_valid[e] &&
            (m_after(m_flag[e], m_val[e], int'(bus.redirect_robFlag), int'(bus.redirect_robValue)) ||
             (bus.redirect_level && m_flag[e] == int'(bus.redirect_robFlag) &&
              m_val[e] == int'(bus.redirect_robValue))))
          m_valid[e] = 1'b0;
      end
    end else begin
      if (e_dv && bus.deq_ready) m_valid[sel] = 1'b0;
      if (e_er && bus.enq_valid) begin
        m_valid[ff] = 1'b1;
        m_flag[ff]  = int'(bus.enq_robFlag);
        m_val[ff]   = int'(bus.enq_robValue);
        for (int s = 0; s < 2; s++) begin
          typ = int'(bus.enq_srcType[2*s +: 2]);
          m_psrc[ff][s] = int'(bus.enq_psrc[s*PREG_W +: PREG_W]);
          m_type[ff][s] = typ;
          m_rdy[ff][s]  = bus.enq_srcReady[s] || m_wake(m_psrc[ff][s], typ) || typ == 0 || typ == 3;
        end
      end
    end
    @(negedge clock);
  endtask

  // Assert reset away from any clock edge and check outputs clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
    check("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
    check("rst_deq_idx", 32'(bus.deq_idx), 32'd0);
    check("rst_deq_robValue", 32'(bus.deq_robValue), 32'd0);
    for (int e = 0; e < int'(ENTRIES); e++) m_valid[e] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    idle();
    for (int e = 0; e < int'(ENTRIES); e++) begin
      m_valid[e] = 0; m_flag[e] = 0; m_val[e] = 0;
      for (int s = 0; s < 2; s++) begin
        m_psrc[e][s] = 0; m_type[e][s] = 0; m_rdy[e][s] = 0;
      end
    end
    @(negedge clock);
    do_reset();

    // 1: two int sources woken on consecutive cycles
    set_enq(5, 9, 4'b0101, 2'b00, 0, 1); step(); idle();
    set_wk(0, 5, 1, 0); step(); idle();
    #1 check("t1_not_yet", 32'(bus.deq_valid), 32'd0);
    set_wk(0, 9, 1, 0); step(); idle();
    #1 check("t1_deq_valid", 32'(bus.deq_valid), 32'd1);
    check("t1_deq_idx", 32'(bus.deq_idx), 32'd0);
    bus.deq_ready = 1; step(); idle();

    // 2: fp source ignores an int-file wakeup, accepts an fp-file one
    set_enq(7, 0, 4'b0010, 2'b00, 0, 2); set_wk(0, 7, 1, 0); step(); idle();
    #1 check("t2_no_wake", 32'(bus.deq_valid), 32'd0);
    set_wk(1, 7, 0, 1); step(); idle();
    #1 check("t2_fp_wake", 32'(bus.deq_valid), 32'd1);
    bus.deq_ready = 1; step(); idle();

    // 3: wakeup bypass into enq
    set_enq(3, 4, 4'b0101, 2'b00, 0, 3); set_wk(0, 4, 1, 0); set_wk(1, 3, 1, 0); step(); idle();
    #1 check("t3_bypass", 32'(bus.deq_valid), 32'd1);
    bus.deq_ready = 1; step(); idle();

    // 4: fill, free slot 3, refill lands in slot 3
    for (int i = 0; i < int'(ENTRIES); i++) begin
      set_enq(20 + i, 30 + i, 4'b0101, (i == 3) ? 2'b11 : 2'b00, 0, i); step(); idle();
    end
    #1 check("t4_full", 32'(bus.enq_ready), 32'd0);
    set_enq(1, 1, 4'b0000, 2'b11, 0, 9); step(); idle();
    #1 check("t4_sel3", 32'(bus.deq_idx), 32'd3);
    bus.deq_ready = 1; step(); idle();
    #1 check("t4_ready_again", 32'(bus.enq_ready), 32'd1);
    set_enq(40, 41, 4'b0101, 2'b11, 1, 17); step(); idle();
    #1 check("t4_refill_slot", 32'(bus.deq_idx), 32'd3);
    check("t4_refill_rob", 32'(bus.deq_robValue), 32'd17);
    do_reset();

    // 5: redirect level 0, level 1 and flag wrap
    set_enq(1, 2, 4'b0101, 2'b11, 0, 2); step();
    set_enq(1, 2, 4'b0101, 2'b11, 0, 4); step();
    set_enq(1, 2, 4'b0101, 2'b11, 0, 6); step(); idle();
    set_redirect(0, 0, 4); step(); idle();
    #1 check("t5a_head", 32'(bus.deq_robValue), 32'd2);
    bus.deq_ready = 1; step(); step(); idle();
    #1 check("t5a_flushed", 32'(bus.deq_valid), 32'd0);
    do_reset();
    set_enq(1, 2, 4'b0101, 2'b11, 0, 2); step();
    set_enq(1, 2, 4'b0101, 2'b11, 0, 4); step();
    set_enq(1, 2, 4'b0101, 2'b11, 0, 6); step(); idle();
    set_redirect(1, 0, 4); step(); idle();
    #1 check("t5b_head", 32'(bus.deq_robValue), 32'd2);
    bus.deq_ready = 1; step(); idle();
    #1 check("t5b_flushed", 32'(bus.deq_valid), 32'd0);
    do_reset();
    set_enq(1, 2, 4'b0000, 2'b00, 1, 1); step(); idle();
    set_redirect(0, 0, 30); step(); idle();
    #1 check("t5c_wrap", 32'(bus.deq_valid), 32'd0);

    // 6: asynchronous reset with live entries
    set_enq(1, 2, 4'b0000, 2'b00, 0, 1); step();
    set_enq(1, 2, 4'b0000, 2'b00, 0, 2); step();
    set_enq(1, 2, 4'b0000, 2'b00, 0, 3); step(); idle();
    #1 check("t6_live", 32'(bus.deq_valid), 32'd1);
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(99) < 60)
        set_enq(int'($urandom_range(7)), int'($urandom_range(7)), 4'($urandom),
                2'(($urandom_range(99) < 30 ? 1 : 0) | ($urandom_range(99) < 30 ? 2 : 0)),
                int'($urandom_range(1)), int'($urandom_range(31)));
      for (int p = 0; p < int'(NUM_WK); p++)
        if ($urandom_range(99) < 70)
          set_wk(p, int'($urandom_range(7)), 1'($urandom), 1'($urandom));
      bus.deq_ready = 1'($urandom);
      if ($urandom_range(99) < 5)
        set_redirect(int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(31)));
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wakeup_status_array.md
Name: wakeup_status_array

Overview:
- Downstream consumer of the wakeup queue outputs. Holds up to ENTRIES waiting micro-ops.
- Per entry, tracks the ready state of two source operands and marks sources ready when a matching physical-destination wakeup arrives.
- Selects one fully-ready entry per cycle for issue.
- Squashes entries younger than a redirect.

Parameters:
- ENTRIES, 8, number of status slots (power of two, ≥2).
- NUM_WK, 2, number of wakeup ports.
- PREG_W, 6, physical register tag width.
- ROB_W, 5, robIdx value width (a flag bit is added on top).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enq_valid  in  1  allocate request.
- enq_ready  out  1  a free slot exists and no redirect is active.
- enq_psrc  in  2*PREG_W  source tags; src0 occupies the low bits.
- enq_srcType  in  4  2 bits per source: 0 = none, 1 = int, 2 = fp, 3 = reserved (treated as none).
- enq_srcReady  in  2  initial ready bit per source.
- enq_robFlag  in  1  robIdx flag of the allocated micro-op.
- enq_robValue  in  ROB_W  robIdx value of the allocated micro-op.
- wk_valid  in  NUM_WK  wakeup valid, one bit per port.
- wk_rfWen  in  NUM_WK  wakeup writes the int register file.
- wk_fpWen  in  NUM_WK  wakeup writes the fp register file.
- wk_pdest  in  NUM_WK*PREG_W  wakeup destination tags.
- deq_valid  out  1  a selected entry is presented.
- deq_ready  in  1  issue accepts the selected entry.
- deq_idx  out  clog2(ENTRIES)  slot index of the selected entry.
- deq_robFlag  out  1  robIdx flag of the selected entry.
- deq_robValue  out  ROB_W  robIdx value of the selected entry.
- redirect_valid  in  1  flush request.
- redirect_level  in  1  0 = flush entries strictly after the redirect robIdx; 1 = also flush the entry with an equal robIdx.
- redirect_robFlag  in  1  redirect robIdx flag.
- redirect_robValue  in  ROB_W  redirect robIdx value.

Behaviour:
- Reset (asynchronous, active-low): all valid bits = 0. Consequently enq_ready = 1, deq_valid = 0, and deq_idx/deq_robFlag/deq_robValue = 0.
- Per-entry state: valid, psrc[2], srcType[2], srcRdy[2], robFlag, robValue.
- Allocation:
  - The lowest-index free slot is chosen.
  - Enq fires when enq_valid & enq_ready; the slot is written at the clock edge.
  - enq_ready = (any slot free) & !redirect_valid.
- Source readiness:
  - A source whose type is none or reserved is always ready.
  - Source s is woken when any port i has wk_valid[i] & (wk_pdest[i] == psrc[s]) and either (type == int & wk_rfWen[i]) or (type == fp & wk_fpWen[i]).
  - Int tag 0 is not special: it still needs a matching wakeup or the initial ready bit.
  - A woken source sets srcRdy at the next edge. Once set, srcRdy stays set until the entry is freed.
- Enq/wakeup bypass: a wakeup in the same cycle as enq also applies to the incoming sources. The stored srcRdy = enq_srcReady | match.
- Selection (combinational):
  - Candidate = valid & both srcRdy set (registered state only; wakeups take one cycle to become issuable).
  - The lowest-index candidate is presented.
  - deq_valid = (any candidate) & !redirect_valid.
  - The deq_* outputs show the selected slot's fields when deq_valid = 1, else 0.
  - deq_valid & deq_ready frees the slot at the edge.
  - The presented entry may change cycle to cycle; deq_valid is a present-and-take handshake, not a hold handshake.
- Redirect:
  - isAfter(a, r) = (a.flag != r.flag) XOR (a.value > r.value).
  - An entry is flushed when valid & (isAfter(entry, redirect) | (redirect_level & entry == redirect)).
  - The flush takes effect at the edge.
  - During redirect_valid there is no enq and no deq.
- Simultaneous events:
  - Free and alloc of different slots in one cycle are both honoured.
  - A slot freed this cycle is not reallocated until the next cycle (the free vector is computed from registered valid bits).
- Full: enq_ready = 0 and no state change from enq.
- Empty: deq_valid = 0.
- Reset asserted mid-operation clears all entries immediately (asynchronously).

Decomposition:
- Shared package holds:
  - SRC_NONE / SRC_INT / SRC_FP encodings.
  - The robIdx struct {flag, value}.
  - The is_after function.
- One natural sub-module: wakeup_src_match, a combinational circuit taking one tag plus its type and all wakeup ports, returning the hit. It is instantiated 2 per entry plus 2 for the enq bypass.
- Priority pick (lowest set bit) is a package function.

Test Plan:
1. Reset, then enq psrc = {5, 9}, types int/int, srcReady = 00. Then wk port 0 pdest = 5 rfWen = 1, and one cycle later wk pdest = 9 rfWen = 1 → deq_valid rises the cycle after the second wakeup, with deq_idx = 0.
2. Enq type fp, psrc = 7, with wakeup pdest = 7 rfWen = 1 fpWen = 0 → no wake. A later wakeup with fpWen = 1 → source ready.
3. Enq and a matching wakeup in the same cycle → entry is stored ready, and deq_valid = 1 on the next cycle.
4. Fill all 8 slots → enq_ready = 0. Deq slot 3 → enq_ready = 1 next cycle, and the next enq lands in slot 3.
5. Entries with robIdx (0, 2), (0, 4), (0, 6). Redirect (0, 4) level 0 → only (0, 6) is flushed. Redirect (0, 4) level 1 → (0, 4) and (0, 6) are flushed. Also check wrap: an entry with (1, 1) vs redirect (0, 30) is flushed.
6. Assert reset while 3 entries are valid and deq_valid = 1 → deq_valid = 0 and enq_ready = 1 immediately, without waiting for a clock edge.
